// File: rtl/ti_lut_pipe.sv
// ti_lut_pipe: registered threshold-implementation component-function lookup.
// OUT_W coordinate functions of one IN_W-bit share-set word come from the packed
// TABLE parameter (bit j of f(i) is TABLE[j*2**IN_W + i]). Results leave only
// from flops, through a valid/ready handshake backed by a 2-entry skid buffer,
// so the block acts as the glitch barrier between shared S-box stages.
// Optional build macro TI_LUT_LOAD_EN: the table becomes a run-time writable
// register array (cfg_we/cfg_addr/cfg_data), initialised from TABLE on reset.
module ti_lut_pipe #(
  parameter int IN_W = 8,
  parameter int OUT_W = 4,
  parameter logic [(OUT_W<<IN_W)-1:0] TABLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       busy_cnt
`ifdef TI_LUT_LOAD_EN
  ,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data
`endif
);

  localparam int Depth = 1 << IN_W;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q;
  logic [OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0] skid_q;
  logic             out_valid_q;

  // Constant table image, regrouped as one OUT_W-bit word per input value.
  logic [OUT_W-1:0] lut_init [Depth];
  logic [OUT_W-1:0] lut_out;

  for (genvar i = 0; i < Depth; i++) begin : g_row
    for (genvar j = 0; j < OUT_W; j++) begin : g_col
      assign lut_init[i][j] = TABLE[j*Depth + i];
    end
  end

`ifdef TI_LUT_LOAD_EN
  logic [OUT_W-1:0] lut_q [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_entry
    // Table entry: reloaded from TABLE on reset, otherwise written by cfg port.
    always_ff @(posedge clk) begin
      if (rst) begin
        lut_q[i] <= lut_init[i];
      end else if (cfg_we && (cfg_addr == IN_W'(i))) begin
        lut_q[i] <= cfg_data;
      end
    end
  end

  // Reads the pre-edge array, so a same-cycle write is seen only afterwards.
  assign lut_out = lut_q[in_data];
`else
  assign lut_out = lut_init[in_data];
`endif

  logic accept;
  logic emit;

  // Ready comes from state only (plus reset), never from out_ready.
  assign in_ready  = ~rst & (state_q != StTwo);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid_q & out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy_cnt  = state_q;

  // Skid-buffer FSM; the lookup result is only ever captured into flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_data_q  <= lut_out;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            out_data_q <= lut_out;
          end else if (accept) begin
            skid_q  <= lut_out;
            state_q <= StTwo;
          end else if (emit) begin
            // out_data keeps its last value; consumers gate on out_valid.
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StTwo: begin
          if (emit) begin
            out_data_q <= skid_q;
            state_q    <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ti_lut_pipe.sv
// Directed bench for ti_lut_pipe (default build, IN_W=8, OUT_W=4).
// Table: bit j of f(i) = parity(i & (8'h0F << j)).
module tb_ti_lut_pipe;

  function automatic logic [3:0] model_f(input logic [7:0] v);
    logic [3:0] r;
    logic [7:0] m;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      m = 8'h0F << j;
      r[j] = ^(v & m);
    end
    return r;
  endfunction

  function automatic logic [1023:0] mk_table();
    logic [1023:0] t;
    logic [3:0] w;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      w = model_f(8'(i));
      for (int j = 0; j < 4; j++) t[j*256 + i] = w[j];
    end
    return t;
  endfunction

  localparam logic [1023:0] TbTable = mk_table();

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  ti_lut_pipe #(
    .IN_W (8),
    .OUT_W(4),
    .TABLE(TbTable)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b0;

    // Reset held three cycles with in_valid high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy_cnt), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x00..0xFF back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(model_f(8'(i))));
      if (i == 8'h13) chk("hand_0x13", 32'(out_data), 32'h0000_000C);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_busy", 32'(busy_cnt), 32'd0);
    chk("stream_end_hold", 32'(out_data), 32'(model_f(8'hFF)));

    // Backpressure: two accepted, third held off
    out_ready = 1'b0;
    in_data   = 8'h01;
    in_valid  = 1'b1;
    tick();
    chk("bp1_busy", 32'(busy_cnt), 32'd1);
    chk("bp1_data", 32'(out_data), 32'(model_f(8'h01)));
    in_data = 8'h02;
    tick();
    chk("bp2_busy", 32'(busy_cnt), 32'd2);
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    chk("bp2_data", 32'(out_data), 32'(model_f(8'h01)));
    in_data = 8'h03;
    tick();
    chk("bp3_busy", 32'(busy_cnt), 32'd2);
    chk("bp3_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_data", 32'(out_data), 32'(model_f(8'h02)));
    chk("bp_drain1_busy", 32'(busy_cnt), 32'd1);
    tick();
    chk("bp_drain2_data", 32'(out_data), 32'(model_f(8'h03)));
    chk("bp_drain2_busy", 32'(busy_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain3_valid", 32'(out_valid), 32'd0);
    chk("bp_drain3_busy", 32'(busy_cnt), 32'd0);

    // Stall stability with in_data toggling
    out_ready = 1'b0;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    held     = model_f(8'hA5);
    for (int k = 0; k < 10; k++) begin
      in_data = 8'($urandom);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    tick();
    chk("stall_drain_busy", 32'(busy_cnt), 32'd0);

    // Mid-operation reset with an in-flight word
    out_ready = 1'b0;
    in_data   = 8'h11;
    in_valid  = 1'b1;
    tick();
    in_data = 8'h22;
    tick();
    chk("mid_full_busy", 32'(busy_cnt), 32'd2);
    rst     = 1'b1;
    in_data = 8'h33;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy_cnt), 32'd0);
    rst       = 1'b0;
    in_data   = 8'h7A;
    out_ready = 1'b1;
    tick();
    chk("mid_7a_data", 32'(out_data), 32'(model_f(8'h7A)));
    chk("mid_7a_busy", 32'(busy_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("mid_end_valid", 32'(out_valid), 32'd0);
    chk("mid_end_busy", 32'(busy_cnt), 32'd0);
    chk("mid_end_hold", 32'(out_data), 32'(model_f(8'h7A)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
